serial_argmax: RTL and testbench

SERIAL_ARGMAX -- requirements
Module: serial_argmax

---
 rtl/serial_argmax_if.sv | 28 ++
 rtl/serial_argmax.sv | 95 +++++++++
 tb/tb_serial_argmax.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_argmax_if.sv
// Handshake bundle for serial_argmax: sample stream in, frame result out.
interface serial_argmax_if #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = 4
) ();
  logic [WIDTH-1:0]   in;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   max;
  logic [IDX_WIDTH-1:0] argmax;
  logic [IDX_WIDTH:0] count;
  logic               trunc;

  // Upstream/downstream side (drives samples, consumes results).
  modport master (
    output in, in_valid, in_last, out_ready,
    input  in_ready, out_valid, max, argmax, count, trunc
  );

  // The argmax block itself.
  modport slave (
    input  in, in_valid, in_last, out_ready,
    output in_ready, out_valid, max, argmax, count, trunc
  );
endinterface

// File: rtl/serial_argmax.sv
// Streaming signed argmax: tracks the running maximum of a frame of samples,
// the index of its first occurrence and the frame length, then presents the
// result until the downstream takes it.
module serial_argmax #(
  parameter int WIDTH     = 4,
  parameter int IDX_WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  serial_argmax_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = '1;
  localparam logic [IDX_WIDTH:0]   CNT_ONE  = (IDX_WIDTH+1)'(1);
  localparam logic [WIDTH-1:0]     MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

  state_t                    state_q, state_d;
  logic signed [WIDTH-1:0]   max_q, max_d;
  logic [IDX_WIDTH-1:0]      argmax_q, argmax_d;
  logic [IDX_WIDTH:0]        count_q, count_d;
  logic                      trunc_q, trunc_d;

  logic                      accept;
  logic                      close;
  logic [IDX_WIDTH-1:0]      cur_idx;
  logic signed [WIDTH-1:0]   in_s;

  assign in_s          = $signed(bus.in);
  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.max       = max_q;
  assign bus.argmax    = argmax_q;
  assign bus.count     = count_q;
  assign bus.trunc     = trunc_q;

  // Next-state and datapath update; the index of the incoming sample is the
  // number of samples already accepted in this frame (zero when idle).
  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    argmax_d = argmax_q;
    count_d  = count_q;
    trunc_d  = trunc_q;
    accept   = bus.in_valid && (state_q != HOLD);
    cur_idx  = (state_q == IDLE) ? '0 : count_q[IDX_WIDTH-1:0];
    close    = bus.in_last || (cur_idx == LAST_IDX);
    case (state_q)
      IDLE: begin
        if (accept) begin
          max_d    = in_s;
          argmax_d = '0;
          count_d  = CNT_ONE;
          trunc_d  = close && !bus.in_last;
          state_d  = close ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Strict compare: ties keep the earlier index.
          if (in_s > max_q) begin
            max_d    = in_s;
            argmax_d = cur_idx;
          end
          count_d = count_q + CNT_ONE;
          trunc_d = close && !bus.in_last;
          if (close) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      max_q    <= MIN_VAL;
      argmax_q <= '0;
      count_q  <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      argmax_q <= argmax_d;
      count_q  <= count_d;
      trunc_q  <= trunc_d;
    end
  end

endmodule

// File: tb/tb_serial_argmax.sv
// Randomized + directed bench for serial_argmax with a queue scoreboard.
module tb_serial_argmax;
  localparam int W  = 4;
  localparam int IW = 4;
  localparam int MAXLEN = 2**IW;
  localparam int BUDGET = 200;

  typedef struct {
    int mx;
    int am;
    int cnt;
    int tr;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   started = 0;
  bit   rnd_rdy = 0;
  bit   hs_prev = 0;
  int   frame[$];
  res_t sb[$];

  serial_argmax_if #(.WIDTH(W), .IDX_WIDTH(IW)) bus ();

  serial_argmax #(.WIDTH(W), .IDX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: max of the frame, first position holding it, length, and
  // whether the frame hit the length limit without a last flag.
  function automatic res_t model(input int f[$], input bit last);
    res_t r;
    r.mx = f[0];
    foreach (f[i]) if (f[i] > r.mx) r.mx = f[i];
    r.am = -1;
    foreach (f[i]) if (r.am < 0 && f[i] == r.mx) r.am = i;
    r.cnt = f.size();
    r.tr  = (!last && f.size() == MAXLEN) ? 1 : 0;
    return r;
  endfunction

  // Monitor: observes accepts to build frames, checks every presented result
  // against the scoreboard front until the handshake pops it.
  always @(negedge clk) begin
    if (!rst) begin
      frame.delete();
      sb.delete();
      hs_prev = 0;
    end else begin
      if (hs_prev) chk("out_valid_pulse", 32'(bus.out_valid), 0);
      if (started) chk("in_ready_decode", 32'(bus.in_ready), 32'(!bus.out_valid));
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          chk("max",    32'($signed(bus.max)), sb[0].mx);
          chk("argmax", 32'(bus.argmax), sb[0].am);
          chk("count",  32'(bus.count), sb[0].cnt);
          chk("trunc",  32'(bus.trunc), sb[0].tr);
          if (bus.out_ready) void'(sb.pop_front());
        end
      end
      hs_prev = bus.out_valid && bus.out_ready;
      if (bus.in_valid && bus.in_ready) begin
        frame.push_back(int'($signed(bus.in)));
        if (bus.in_last || frame.size() == MAXLEN) begin
          sb.push_back(model(frame, bus.in_last));
          frame.delete();
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Presents one sample and waits until it is accepted; returns edges waited.
  task automatic send(input int d, input bit l, output int waited);
    bit acc;
    bus.in       = W'(d);
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    waited = 0;
    do begin
      acc = bus.in_ready;
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      cyc();
      waited++;
    end while (!acc && waited < BUDGET);
    if (!acc) chk("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
  endtask

  initial begin
    int w;
    int len;
    rst = 1'b0;
    bus.in = '0;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_max",       32'($signed(bus.max)), -8);
    chk("rst_argmax",    32'(bus.argmax), 0);
    chk("rst_count",     32'(bus.count), 0);
    chk("rst_trunc",     32'(bus.trunc), 0);
    rst = 1'b1;
    started = 1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);

    // Ramp -8..7, last on 7.
    for (int v = -8; v <= 7; v++) send(v, v == 7, w);
    gap(3);
    // Ties.
    send(3, 0, w); send(-1, 0, w); send(3, 0, w); send(2, 1, w);
    gap(2);
    // Truncation by length.
    repeat (MAXLEN) send(-8, 0, w);
    gap(2);

    // Backpressure with upstream holding a sample.
    bus.out_ready = 1'b0;
    send(2, 0, w); send(5, 1, w);
    bus.in = W'(-3); bus.in_last = 1'b1; bus.in_valid = 1'b1;
    repeat (5) begin
      chk("bp_in_ready", 32'(bus.in_ready), 0);
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      cyc();
    end
    bus.out_ready = 1'b1;
    send(-3, 1, w);
    chk("bp_restart_latency", w, 2);
    gap(2);

    // Gaps and single-sample frame.
    send(5, 1, w);
    send(-2, 0, w); gap(1); send(6, 0, w); gap(1); send(1, 1, w);
    gap(2);

    // Reset mid-frame discards it.
    send(4, 0, w); send(6, 0, w);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    send(1, 1, w);
    gap(2);

    // Random frames with random gaps and random downstream stalls.
    rnd_rdy = 1;
    repeat (40) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        send(int'($signed(W'($urandom))), i == len - 1, w);
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end
    end
    rnd_rdy = 0;
    bus.out_ready = 1'b1;
    gap(5);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
